// File: rtl/pwm_ramp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ramp_pkg
// Purpose  : Shared types and constants for the PWM speed-ramp controller.
//            Holds the ramp FSM state encoding, the speed width and range,
//            and a saturating single-step helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pwm_ramp_pkg;

    localparam int                   SPEED_W   = 3;
    localparam logic [SPEED_W-1:0]   SPEED_MAX = 3'd7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAMP     = 2'd1,
        HOLD     = 2'd2,
        STOPPING = 2'd3
    } ramp_state_e;

    // One step from cur toward tgt. Clamped at both ends of the range so
    // the speed can never wrap, and never moves past the target.
    function automatic logic [SPEED_W-1:0] step_toward(
        input logic [SPEED_W-1:0] cur,
        input logic [SPEED_W-1:0] tgt
    );
        logic [SPEED_W-1:0] nxt;
        nxt = cur;
        if ((cur < tgt) && (cur != SPEED_MAX)) begin
            nxt = cur + 1'b1;
        end else if ((cur > tgt) && (cur != '0)) begin
            nxt = cur - 1'b1;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/input_debounce.sv
`default_nettype none
// ============================================================================
// Module   : input_debounce
// Purpose  : Two-flop synchronizer followed by an optional debouncer. A new
//            value is accepted once the synchronized word has been stable
//            for CYCLES consecutive cycles after capture. CYCLES = 0 bypasses
//            the debouncer and presents the synchronizer output directly.
// Ports    : clk     in  1      system clock
//            rst_n   in  1      synchronous active-low reset
//            i_din   in  WIDTH  raw asynchronous input word
//            o_dout  out WIDTH  synchronized (and debounced) word, registered
// Revision : 1.0 - initial release
// ============================================================================
module input_debounce #(
    parameter int WIDTH  = 4,
    parameter int CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [WIDTH-1:0] r_sync1_q;
    logic [WIDTH-1:0] r_sync2_q;
    logic [WIDTH-1:0] w_sync1_d;
    logic [WIDTH-1:0] w_sync2_d;

    always_comb begin
        w_sync1_d = i_din;
        w_sync2_d = r_sync1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1_q <= '0;
            r_sync2_q <= '0;
        end else begin
            r_sync1_q <= w_sync1_d;
            r_sync2_q <= w_sync2_d;
        end
    end

    generate
        if (CYCLES == 0) begin : g_sync_only
            assign o_dout = r_sync2_q;
        end else begin : g_debounce
            localparam int                c_cnt_w    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
            localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CYCLES - 1);

            logic [WIDTH-1:0]   r_cand_q;
            logic [WIDTH-1:0]   w_cand_d;
            logic [WIDTH-1:0]   r_out_q;
            logic [WIDTH-1:0]   w_out_d;
            logic [c_cnt_w-1:0] r_cnt_q;
            logic [c_cnt_w-1:0] w_cnt_d;

            // Any difference restarts the stability window; the counter then
            // parks at its last value and keeps re-loading the same word.
            always_comb begin
                w_cand_d = r_cand_q;
                w_cnt_d  = r_cnt_q;
                w_out_d  = r_out_q;
                if (r_sync2_q != r_cand_q) begin
                    w_cand_d = r_sync2_q;
                    w_cnt_d  = '0;
                end else if (r_cnt_q == c_cnt_last) begin
                    w_out_d  = r_cand_q;
                end else begin
                    w_cnt_d  = r_cnt_q + c_cnt_w'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_cand_q <= '0;
                    r_cnt_q  <= '0;
                    r_out_q  <= '0;
                end else begin
                    r_cand_q <= w_cand_d;
                    r_cnt_q  <= w_cnt_d;
                    r_out_q  <= w_out_d;
                end
            end

            assign o_dout = r_out_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/pwm_speed_ramp.sv
`default_nettype none
// ============================================================================
// Module   : pwm_speed_ramp
// Purpose  : Control stage ahead of a PWM generator. Debounces the speed and
//            run requests, then ramps the generator speed one step per
//            STEP_CYCLES toward the accepted target (soft start, soft stop,
//            retargeting). A synchronized emergency stop bypasses the ramp.
// Ports    : clk        in  1  system clock
//            rst_n      in  1  synchronous active-low reset
//            req_speed  in  3  raw requested speed
//            req_enable in  1  raw run request
//            estop      in  1  raw emergency stop, active high
//            speed      out 3  speed to PWM generator
//            enable     out 1  enable to PWM generator
//            busy       out 1  ramping or stopping
//            at_target  out 1  holding at the accepted target
// Revision : 1.0 - initial release
// ============================================================================
module pwm_speed_ramp
    import pwm_ramp_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int STEP_CYCLES     = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SPEED_W-1:0] req_speed,
    input  logic               req_enable,
    input  logic               estop,
    output logic [SPEED_W-1:0] speed,
    output logic               enable,
    output logic               busy,
    output logic               at_target
);

    localparam int                 c_tmr_w    = $clog2(STEP_CYCLES);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(STEP_CYCLES - 1);

    logic [SPEED_W:0]   w_req_raw;
    logic [SPEED_W:0]   w_tgt;
    logic               w_tgt_en;
    logic [SPEED_W-1:0] w_tgt_speed;
    logic               w_estop_s;

    assign w_req_raw   = {req_enable, req_speed};
    assign w_tgt_en    = w_tgt[SPEED_W];
    assign w_tgt_speed = w_tgt[SPEED_W-1:0];

    input_debounce #(
        .WIDTH  (SPEED_W + 1),
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_req_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_din  (w_req_raw),
        .o_dout (w_tgt)
    );

    // E-stop is only synchronized so it acts within three cycles.
    input_debounce #(
        .WIDTH  (1),
        .CYCLES (0)
    ) u_estop_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_din  (estop),
        .o_dout (w_estop_s)
    );

    ramp_state_e        r_state_q;
    ramp_state_e        w_state_d;
    logic [SPEED_W-1:0] r_speed_q;
    logic [SPEED_W-1:0] w_speed_d;
    logic               r_enable_q;
    logic               w_enable_d;
    logic               r_busy_q;
    logic               w_busy_d;
    logic               r_at_target_q;
    logic               w_at_target_d;
    logic [c_tmr_w-1:0] r_tmr_q;
    logic [c_tmr_w-1:0] w_tmr_d;

    logic               w_tick;
    logic [c_tmr_w-1:0] w_tmr_run;
    logic [SPEED_W-1:0] w_stepped;

    assign w_tick    = (r_tmr_q == c_tmr_last);
    assign w_tmr_run = w_tick ? '0 : (r_tmr_q + c_tmr_w'(1));
    // Direction comes from the live target at each step point, so a
    // retarget (or reversal) mid-ramp never restarts the dwell timer.
    assign w_stepped = step_toward(r_speed_q, w_tgt_speed);

    always_comb begin
        w_state_d  = r_state_q;
        w_speed_d  = r_speed_q;
        w_enable_d = r_enable_q;
        w_tmr_d    = r_tmr_q;
        if (w_estop_s) begin
            w_state_d  = IDLE;
            w_speed_d  = '0;
            w_enable_d = 1'b0;
            w_tmr_d    = '0;
        end else begin
            case (r_state_q)
                IDLE: begin
                    w_speed_d  = '0;
                    w_enable_d = 1'b0;
                    w_tmr_d    = '0;
                    if (w_tgt_en) begin
                        w_enable_d = 1'b1;
                        w_state_d  = (w_tgt_speed == '0) ? HOLD : RAMP;
                    end
                end
                RAMP: begin
                    w_tmr_d = w_tmr_run;
                    if (!w_tgt_en) begin
                        // Already at zero: nothing to ramp down, stop now.
                        if (r_speed_q == '0) begin
                            w_state_d  = IDLE;
                            w_enable_d = 1'b0;
                            w_tmr_d    = '0;
                        end else begin
                            w_state_d  = STOPPING;
                        end
                    end else if (w_tick) begin
                        w_speed_d = w_stepped;
                        if (w_stepped == w_tgt_speed) begin
                            w_state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!w_tgt_en) begin
                        w_tmr_d = '0;
                        if (r_speed_q == '0) begin
                            w_state_d  = IDLE;
                            w_enable_d = 1'b0;
                        end else begin
                            w_state_d  = STOPPING;
                        end
                    end else if (w_tgt_speed != r_speed_q) begin
                        w_state_d = RAMP;
                        w_tmr_d   = '0;
                    end
                end
                STOPPING: begin
                    w_tmr_d = w_tmr_run;
                    if (w_tgt_en) begin
                        w_state_d = RAMP;
                    end else if (w_tick) begin
                        // Zero is dwelt at for one full step before the
                        // generator is released.
                        if (r_speed_q == '0) begin
                            w_state_d  = IDLE;
                            w_enable_d = 1'b0;
                            w_tmr_d    = '0;
                        end else begin
                            w_speed_d = r_speed_q - 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_d  = IDLE;
                    w_speed_d  = '0;
                    w_enable_d = 1'b0;
                    w_tmr_d    = '0;
                end
            endcase
        end
        w_busy_d      = (w_state_d == RAMP) || (w_state_d == STOPPING);
        w_at_target_d = (w_state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q     <= IDLE;
            r_speed_q     <= '0;
            r_enable_q    <= 1'b0;
            r_busy_q      <= 1'b0;
            r_at_target_q <= 1'b0;
            r_tmr_q       <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_speed_q     <= w_speed_d;
            r_enable_q    <= w_enable_d;
            r_busy_q      <= w_busy_d;
            r_at_target_q <= w_at_target_d;
            r_tmr_q       <= w_tmr_d;
        end
    end

    assign speed     = r_speed_q;
    assign enable    = r_enable_q;
    assign busy      = r_busy_q;
    assign at_target = r_at_target_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_speed_ramp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pwm_speed_ramp
// Purpose  : Self-checking bench for pwm_speed_ramp with DEBOUNCE_CYCLES=4
//            and STEP_CYCLES=8. A cycle-level behavioural model predicts the
//            outputs every cycle; directed scenarios add literal checks.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_speed_ramp;

    localparam int DEB  = 4;
    localparam int STEP = 8;

    localparam int M_IDLE = 0;
    localparam int M_RAMP = 1;
    localparam int M_HOLD = 2;
    localparam int M_STOP = 3;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic [2:0] req_speed  = 3'd0;
    logic       req_enable = 1'b0;
    logic       estop      = 1'b0;
    logic [2:0] speed;
    logic       enable;
    logic       busy;
    logic       at_target;

    pwm_speed_ramp #(
        .DEBOUNCE_CYCLES (DEB),
        .STEP_CYCLES     (STEP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_speed  (req_speed),
        .req_enable (req_enable),
        .estop      (estop),
        .speed      (speed),
        .enable     (enable),
        .busy       (busy),
        .at_target  (at_target)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. Raw samples are kept as a history; a request is
    // accepted when the sample two edges back and the DEB before it agree
    // (synchronizer delay plus DEB+1 equal samples). Steps are scheduled
    // as absolute cycle deadlines.
    // ------------------------------------------------------------------
    logic [3:0] wq[$];
    logic       eq[$];
    int  cyc        = 0;
    int  m_mode     = M_IDLE;
    int  m_deadline = 0;
    int  m_speed    = 0;
    bit  m_en       = 0;
    bit  m_tgt_en   = 0;
    int  m_tgt_sp   = 0;
    bit  m_estop_s  = 0;
    bit  chk_on     = 0;
    bit  o_en;
    int  o_sp;
    bit  o_es;
    bit  stable;
    logic [3:0] w_tmp;

    always @(posedge clk) begin
        if (!rst_n) begin
            wq.delete();
            eq.delete();
            repeat (DEB + 3) wq.push_back(4'd0);
            repeat (3) eq.push_back(1'b0);
            m_mode = M_IDLE; m_speed = 0; m_en = 0;
            m_tgt_en = 0; m_tgt_sp = 0; m_estop_s = 0;
            chk_on = 1;
        end else begin
            o_en = m_tgt_en;
            o_sp = m_tgt_sp;
            o_es = m_estop_s;
            wq.push_front({req_enable, req_speed});
            void'(wq.pop_back());
            eq.push_front(estop);
            void'(eq.pop_back());
            stable = 1;
            for (int i = 3; i <= DEB + 2; i++) if (wq[i] != wq[2]) stable = 0;
            if (stable) begin
                w_tmp    = wq[2];
                m_tgt_en = w_tmp[3];
                m_tgt_sp = int'(w_tmp[2:0]);
            end
            m_estop_s = eq[1];

            if (o_es) begin
                m_mode = M_IDLE; m_speed = 0; m_en = 0;
            end else begin
                case (m_mode)
                    M_IDLE: if (o_en) begin
                        m_en = 1;
                        m_mode = (o_sp == 0) ? M_HOLD : M_RAMP;
                        m_deadline = cyc + STEP;
                    end
                    M_RAMP: begin
                        if (!o_en) begin
                            if (m_speed == 0) begin m_mode = M_IDLE; m_en = 0; end
                            else begin
                                m_mode = M_STOP;
                                if (cyc == m_deadline) m_deadline += STEP;
                            end
                        end else if (cyc == m_deadline) begin
                            if (m_speed < o_sp) m_speed++;
                            else if (m_speed > o_sp) m_speed--;
                            if (m_speed == o_sp) m_mode = M_HOLD;
                            m_deadline += STEP;
                        end
                    end
                    M_HOLD: begin
                        if (!o_en) begin
                            if (m_speed == 0) begin m_mode = M_IDLE; m_en = 0; end
                            else begin m_mode = M_STOP; m_deadline = cyc + STEP; end
                        end else if (o_sp != m_speed) begin
                            m_mode = M_RAMP; m_deadline = cyc + STEP;
                        end
                    end
                    default: begin
                        if (o_en) begin
                            m_mode = M_RAMP;
                            if (cyc == m_deadline) m_deadline += STEP;
                        end else if (cyc == m_deadline) begin
                            if (m_speed == 0) begin m_mode = M_IDLE; m_en = 0; end
                            else m_speed--;
                            m_deadline += STEP;
                        end
                    end
                endcase
            end
        end
        cyc++;
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            n_checks++;
            if ({speed, enable, busy, at_target} !==
                {3'(m_speed), m_en, (m_mode == M_RAMP) || (m_mode == M_STOP), m_mode == M_HOLD}) begin
                n_fail++;
                $display("FAIL model_cycle %0d: dut spd=%0d en=%b busy=%b at=%b, model spd=%0d en=%b mode=%0d",
                         cyc, speed, enable, busy, at_target, m_speed, m_en, m_mode);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed scenarios (inputs change on the falling edge).
    // ------------------------------------------------------------------
    initial begin
        // Reset for 3 edges with inputs toggling.
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            req_speed  = 3'($urandom_range(0, 7));
            req_enable = ~req_enable;
            estop      = ~estop;
        end
        check("rst_speed", 8'(speed), 8'd0);
        check("rst_enable", 8'(enable), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_at_target", 8'(at_target), 8'd0);
        req_speed = 3'd0; req_enable = 1'b0; estop = 1'b0;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_enable", 8'(enable), 8'd0);
        check("post_rst_speed", 8'(speed), 8'd0);

        // Soft start to 5.
        req_enable = 1'b1; req_speed = 3'd5;
        repeat (7) @(negedge clk);
        check("start_en_early", 8'(enable), 8'd0);
        @(negedge clk);
        check("start_en", 8'(enable), 8'd1);
        check("start_busy", 8'(busy), 8'd1);
        check("start_speed0", 8'(speed), 8'd0);
        for (int s = 1; s <= 5; s++) begin
            repeat (8) @(negedge clk);
            check("start_step", 8'(speed), 8'(s));
        end
        check("start_at_target", 8'(at_target), 8'd1);
        check("start_busy_done", 8'(busy), 8'd0);

        // Glitch of 3 cycles must be rejected.
        req_speed = 3'd7;
        repeat (3) @(negedge clk);
        req_speed = 3'd5;
        repeat (20) @(negedge clk);
        check("glitch_speed", 8'(speed), 8'd5);
        check("glitch_at_target", 8'(at_target), 8'd1);

        // Move to hold at 4.
        req_speed = 3'd4;
        repeat (16) @(negedge clk);
        check("hold4_speed", 8'(speed), 8'd4);
        check("hold4_at_target", 8'(at_target), 8'd1);

        // Soft stop.
        req_enable = 1'b0;
        repeat (8) @(negedge clk);
        check("stop_busy", 8'(busy), 8'd1);
        check("stop_speed4", 8'(speed), 8'd4);
        for (int s = 3; s >= 0; s--) begin
            repeat (8) @(negedge clk);
            check("stop_step", 8'(speed), 8'(s));
        end
        repeat (7) @(negedge clk);
        check("stop_en_held", 8'(enable), 8'd1);
        @(negedge clk);
        check("stop_en_off", 8'(enable), 8'd0);
        check("stop_busy_off", 8'(busy), 8'd0);

        // Retarget mid-ramp: 0->6, redirect to 2 at speed 3.
        req_enable = 1'b1; req_speed = 3'd6;
        repeat (32) @(negedge clk);
        check("retgt_speed3", 8'(speed), 8'd3);
        req_speed = 3'd2;
        repeat (7) @(negedge clk);
        check("retgt_no_overshoot", 8'(speed), 8'd3);
        @(negedge clk);
        check("retgt_speed2", 8'(speed), 8'd2);
        check("retgt_hold", 8'(at_target), 8'd1);
        repeat (16) @(negedge clk);
        check("retgt_stays", 8'(speed), 8'd2);

        // E-stop while ramping at 3.
        req_speed = 3'd5;
        repeat (16) @(negedge clk);
        check("estop_pre_speed", 8'(speed), 8'd3);
        estop = 1'b1;
        repeat (2) @(negedge clk);
        check("estop_latency_en", 8'(enable), 8'd1);
        @(negedge clk);
        check("estop_en", 8'(enable), 8'd0);
        check("estop_speed", 8'(speed), 8'd0);
        repeat (10) @(negedge clk);
        check("estop_held", 8'(enable), 8'd0);
        estop = 1'b0;
        repeat (3) @(negedge clk);
        check("estop_restart_en", 8'(enable), 8'd1);
        check("estop_restart_spd", 8'(speed), 8'd0);
        repeat (8) @(negedge clk);
        check("estop_restart_step", 8'(speed), 8'd1);

        // E-stop together with a target change.
        estop = 1'b1; req_speed = 3'd1;
        repeat (15) @(negedge clk);
        check("estop_chg_en", 8'(enable), 8'd0);
        check("estop_chg_speed", 8'(speed), 8'd0);
        check("estop_chg_busy", 8'(busy), 8'd0);
        check("estop_chg_at", 8'(at_target), 8'd0);
        estop = 1'b0;
        repeat (20) @(negedge clk);
        check("final_speed", 8'(speed), 8'd1);
        check("final_at_target", 8'(at_target), 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_speed_ramp.md
# pwm_speed_ramp

Upstream control stage for `PWM_module`. It takes raw switch inputs for requested speed and enable, then synchronizes and debounces them. It then drives the PWM generator's `speed[2:0]` and `enable` so that speed changes one step at a time at a fixed dwell rate: soft start, soft stop and glitch-free retargeting. A separate emergency-stop input bypasses the ramp.

## Interface
- `DEBOUNCE_CYCLES`, default 1000: consecutive stable cycles required before a request change is accepted (≥2).
- `STEP_CYCLES`, default 50000: dwell cycles between successive speed steps (≥2).
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; **synchronous, active-low** (sampled on `clk` rising edge)
- `req_speed`  in  3  raw requested speed (switches)
- `req_enable`  in  1  raw run request
- `estop`  in  1  raw emergency stop, active high
- `speed`  out  3  speed to PWM generator
- `enable`  out  1  enable to PWM generator
- `busy`  out  1  high while ramping or stopping
- `at_target`  out  1  high in HOLD (speed equals accepted target)

## Operation
- **Reset** (`rst_n`=0 at an edge) has priority over everything. It clears:
  - all sync and debounce flops and the accepted target (speed 0, disabled);
  - `speed`=0, `enable`=0, `busy`=0, `at_target`=0;
  - FSM state to IDLE.
- **Sync:** two-flop synchronizer on `req_speed`, `req_enable` and `estop`.
- **Debounce:** applies to `{req_enable, req_speed}` as one 4-bit word.
  - If the synchronized word ≠ candidate, capture the word into candidate and clear the counter.
  - Otherwise, when the counter reaches DEBOUNCE_CYCLES−1, load the accepted target (`tgt_en`, `tgt_speed`).
  - Otherwise, increment the counter.
  - `estop` is synchronized only, not debounced.
- **FSM** (`estop_s` = synchronized estop):
  - **IDLE:** `enable`=0, `speed`=0.
    - If `tgt_en` and not `estop_s`, set `enable`=1 and go to RAMP, or to HOLD if `tgt_speed`=0.
  - **RAMP:** the step timer runs. When the timer reaches STEP_CYCLES−1:
    - `speed` moves ±1 toward `tgt_speed` and the timer clears;
    - if the new speed equals `tgt_speed`, go to HOLD.
    - Direction is re-evaluated at every step, so a target change mid-ramp (including a reversal) takes effect at the next step without restarting the timer.
    - If `tgt_en` drops, go to STOPPING (timer continues).
  - **HOLD:**
    - If `tgt_speed` ≠ `speed`, go to RAMP with the timer cleared.
    - If `tgt_en` drops, go to STOPPING with the timer cleared.
  - **STOPPING:** steps −1 per STEP_CYCLES.
    - When `speed` is 0 at a step point, or immediately on entry if already 0, deassert `enable` on that edge and go to IDLE.
    - If `tgt_en` reasserts, go to RAMP (timer continues).
- **E-stop:** `estop_s`=1 in any state forces `speed`=0, `enable`=0 and IDLE on the next edge. IDLE is held while `estop_s`=1. After release, a still-enabled request restarts the ramp from 0.
- **Outputs:** `busy` = RAMP or STOPPING; `at_target` = HOLD.
- **Range:** `speed` stays in 0..7 and never wraps; the ramp never steps past the target.

## Timing
- All outputs are registered.
- Raw request change to accepted-target change: 2 (sync) + 1 (capture) + DEBOUNCE_CYCLES cycles.
- Accepted `tgt_en`=1 in IDLE to `enable`=1: 1 cycle.
- Entry into RAMP to first step: STEP_CYCLES cycles. Each subsequent step follows STEP_CYCLES cycles after the previous one.
- Raw `estop` rise to `enable`=0 and `speed`=0: 3 cycles.
- A glitch shorter than DEBOUNCE_CYCLES stable cycles is never accepted.

## Structure
- **Package `pwm_ramp_pkg`:**
  - FSM state enum: IDLE, RAMP, HOLD, STOPPING;
  - `SPEED_W`=3 and `SPEED_MAX`=7.
- **Sub-module `input_debounce`:**
  - parameters: width, cycles;
  - contains the sync and debounce logic;
  - instantiated once for the 4-bit request and once with cycles bypassed (sync only) for `estop`.
- The top level `pwm_speed_ramp` holds the FSM and the step timer. The timer width is `$clog2(STEP_CYCLES)`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and STEP_CYCLES=8.
- **Reset:** hold `rst_n`=0 for 3 cycles with inputs toggling → all outputs 0; after release, outputs stay 0 while `req_enable`=0.
- **Soft start:** `req_enable`=1, `req_speed`=5 → `enable`=1 at cycle 8 after the change. `speed` reads 1,2,3,4,5 at 8-cycle intervals. `at_target`=1 from the 5th step, `busy`=0.
- **Glitch rejection:** in HOLD at 5, pulse `req_speed`=7 for 3 cycles → `speed` and the target are unchanged, `busy` stays 0.
- **Retarget mid-ramp:** ramping 0→6; at `speed`=3, set `req_speed`=2 → next step gives `speed`=2, then HOLD, with no overshoot.
- **Soft stop:** in HOLD at 4, drop `req_enable` → `speed` goes 3,2,1,0 at 8-cycle steps. `enable` falls on the edge after `speed` is 0 at a step point (8 cycles after the step to 0), then IDLE.
- **E-stop:** at `speed`=3, assert `estop` → `enable`=0 and `speed`=0 after 3 cycles, held while asserted. On release with `req_enable`=1, `speed`=5: the ramp restarts from 0. Asserting `estop` together with a target change leaves IDLE as the result.
